// File: rtl/fxdp_cr_exec_if.sv
// rtl/fxdp_cr_exec_if.sv - decoded-bundle handshake, stall and result bus for fxdp_cr_exec
interface fxdp_cr_exec_if;
   logic        in_valid;
   logic        in_ready;
   logic        crl_en;
   logic [2:0]  cr_op;
   logic [4:0]  crl_ba;
   logic [4:0]  crl_bb;
   logic [4:0]  crl_bt;
   logic [2:0]  reg_mv;
   logic [7:0]  src_cr;
   logic [31:0] gpr_in;
   logic        stall;
   logic        out_valid;
   logic        gpr_we;
   logic [31:0] gpr_out;
   logic [31:0] cr;

   modport master (
      output in_valid, crl_en, cr_op, crl_ba, crl_bb, crl_bt, reg_mv, src_cr, gpr_in, stall,
      input  in_ready, out_valid, gpr_we, gpr_out, cr
   );

   modport slave (
      input  in_valid, crl_en, cr_op, crl_ba, crl_bb, crl_bt, reg_mv, src_cr, gpr_in, stall,
      output in_ready, out_valid, gpr_we, gpr_out, cr
   );
endinterface

// File: rtl/fxdp_cr_exec.sv
// rtl/fxdp_cr_exec.sv - two-stage CR logical/move unit; FXDP_CR_FWD_EN enables S2->S1 CR forwarding
module fxdp_cr_exec (
   input  logic          clk,
   input  logic          reset,
   fxdp_cr_exec_if.slave bus
);
   localparam logic [2:0] MV_CTC = 3'd1;
   localparam logic [2:0] MV_GTC = 3'd2;
   localparam logic [2:0] MV_CTG = 3'd3;

   logic        rdy_q, rdy_d;
   logic        s1_valid_q, s1_valid_d;
   logic        s1_crl_q, s1_crl_d;
   logic [2:0]  s1_op_q, s1_op_d;
   logic [4:0]  s1_ba_q, s1_ba_d;
   logic [4:0]  s1_bb_q, s1_bb_d;
   logic [4:0]  s1_bt_q, s1_bt_d;
   logic [2:0]  s1_mv_q, s1_mv_d;
   logic [7:0]  s1_src_q, s1_src_d;
   logic [31:0] s1_gpr_q, s1_gpr_d;
   logic        s2_valid_q, s2_valid_d;
   logic        s2_cr_we_q, s2_cr_we_d;
   logic [31:0] s2_cr_q, s2_cr_d;
   logic        s2_gpr_we_q, s2_gpr_we_d;
   logic [31:0] s2_gpr_q, s2_gpr_d;
   logic [31:0] cr_q, cr_d;

   logic        s2_pending;
   logic        hazard;
   logic [31:0] op_cr;
   logic        in_ready_w;
   logic        accept;
   logic [31:0] res_cr;
   logic        res_cr_we;
   logic        res_gpr_we;
   logic [31:0] res_gpr;
   logic        bit_a, bit_b, bit_r;
   logic        ctc_hit;
   logic [3:0]  ctc_fld;

   assign s2_pending = s2_valid_q & s2_cr_we_q;

`ifdef FXDP_CR_FWD_EN
   assign op_cr  = s2_pending ? s2_cr_q : cr_q;
   assign hazard = 1'b0;
`else
   logic s1_reads_cr;
   assign s1_reads_cr = s1_crl_q | (s1_mv_q == MV_CTC) | (s1_mv_q == MV_GTC) | (s1_mv_q == MV_CTG);
   assign op_cr  = cr_q;
   assign hazard = s2_pending & s1_valid_q & s1_reads_cr;
`endif

   assign in_ready_w = rdy_q & ~bus.stall & ~hazard;
   assign accept     = bus.in_valid & in_ready_w;

   // S1 compute: full next-CR image and mfocrf value from the operand view of CR
   always_comb begin
      res_cr     = op_cr;
      res_cr_we  = 1'b0;
      res_gpr_we = 1'b0;
      res_gpr    = '0;
      bit_a      = op_cr[~s1_ba_q];
      bit_b      = op_cr[~s1_bb_q];
      bit_r      = 1'b0;
      ctc_hit    = 1'b0;
      ctc_fld    = '0;
      if (s1_crl_q) begin
         case (s1_op_q)
            3'd0:    bit_r = bit_a & bit_b;
            3'd1:    bit_r = ~(bit_a & bit_b);
            3'd2:    bit_r = bit_a | bit_b;
            3'd3:    bit_r = ~(bit_a | bit_b);
            3'd4:    bit_r = bit_a ^ bit_b;
            3'd5:    bit_r = ~(bit_a ^ bit_b);
            3'd6:    bit_r = bit_a & ~bit_b;
            default: bit_r = bit_a | ~bit_b;
         endcase
         res_cr[~s1_bt_q] = bit_r;
         res_cr_we        = 1'b1;
      end else begin
         case (s1_mv_q)
            MV_CTC: begin
               for (int f = 0; f < 8; f++) begin
                  if (s1_src_q[7-f] && !ctc_hit) begin
                     ctc_hit = 1'b1;
                     ctc_fld = op_cr[28-4*f +: 4];
                  end
               end
               if (ctc_hit) begin
                  res_cr[{~s1_bt_q[4:2], 2'b00} +: 4] = ctc_fld;
               end
               res_cr_we = ctc_hit;
            end
            MV_GTC: begin
               for (int f = 0; f < 8; f++) begin
                  if (s1_src_q[7-f]) begin
                     res_cr[28-4*f +: 4] = s1_gpr_q[28-4*f +: 4];
                  end
               end
               res_cr_we = 1'b1;
            end
            MV_CTG: begin
               for (int f = 0; f < 8; f++) begin
                  if (s1_src_q[7-f]) begin
                     res_gpr[28-4*f +: 4] = op_cr[28-4*f +: 4];
                  end
               end
               res_gpr_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Pipeline advance: stall freezes everything; a hazard holds S1 while S2 drains
   always_comb begin
      rdy_d       = 1'b1;
      s1_valid_d  = s1_valid_q;
      s1_crl_d    = s1_crl_q;
      s1_op_d     = s1_op_q;
      s1_ba_d     = s1_ba_q;
      s1_bb_d     = s1_bb_q;
      s1_bt_d     = s1_bt_q;
      s1_mv_d     = s1_mv_q;
      s1_src_d    = s1_src_q;
      s1_gpr_d    = s1_gpr_q;
      s2_valid_d  = s2_valid_q;
      s2_cr_we_d  = s2_cr_we_q;
      s2_cr_d     = s2_cr_q;
      s2_gpr_we_d = s2_gpr_we_q;
      s2_gpr_d    = s2_gpr_q;
      cr_d        = cr_q;
      if (!bus.stall) begin
         if (s2_pending) begin
            cr_d = s2_cr_q;
         end
         s2_valid_d  = s1_valid_q & ~hazard;
         s2_cr_we_d  = s1_valid_q & ~hazard & res_cr_we;
         s2_cr_d     = res_cr;
         s2_gpr_we_d = res_gpr_we;
         s2_gpr_d    = res_gpr;
         if (!hazard) begin
            s1_valid_d = accept;
            if (accept) begin
               s1_crl_d = bus.crl_en;
               s1_op_d  = bus.cr_op;
               s1_ba_d  = bus.crl_ba;
               s1_bb_d  = bus.crl_bb;
               s1_bt_d  = bus.crl_bt;
               s1_mv_d  = bus.reg_mv;
               s1_src_d = bus.src_cr;
               s1_gpr_d = bus.gpr_in;
            end
         end
      end
   end

   // State registers; reset squashes both stages and clears architectural CR at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_crl_q    <= 1'b0;
         s1_op_q     <= '0;
         s1_ba_q     <= '0;
         s1_bb_q     <= '0;
         s1_bt_q     <= '0;
         s1_mv_q     <= '0;
         s1_src_q    <= '0;
         s1_gpr_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_cr_we_q  <= 1'b0;
         s2_cr_q     <= '0;
         s2_gpr_we_q <= 1'b0;
         s2_gpr_q    <= '0;
         cr_q        <= '0;
      end else begin
         rdy_q       <= rdy_d;
         s1_valid_q  <= s1_valid_d;
         s1_crl_q    <= s1_crl_d;
         s1_op_q     <= s1_op_d;
         s1_ba_q     <= s1_ba_d;
         s1_bb_q     <= s1_bb_d;
         s1_bt_q     <= s1_bt_d;
         s1_mv_q     <= s1_mv_d;
         s1_src_q    <= s1_src_d;
         s1_gpr_q    <= s1_gpr_d;
         s2_valid_q  <= s2_valid_d;
         s2_cr_we_q  <= s2_cr_we_d;
         s2_cr_q     <= s2_cr_d;
         s2_gpr_we_q <= s2_gpr_we_d;
         s2_gpr_q    <= s2_gpr_d;
         cr_q        <= cr_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = s2_valid_q;
   assign bus.gpr_we    = s2_valid_q & s2_gpr_we_q;
   assign bus.gpr_out   = s2_valid_q ? s2_gpr_q : '0;
   assign bus.cr        = cr_q;
endmodule

// File: tb/tb_fxdp_cr_exec.sv
// tb/tb_fxdp_cr_exec.sv - directed vectors, corner sequences and random run for fxdp_cr_exec
module tb_fxdp_cr_exec;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   fxdp_cr_exec_if ifc ();

   fxdp_cr_exec dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        crl_en;
      logic [2:0]  op;
      logic [4:0]  ba;
      logic [4:0]  bb;
      logic [4:0]  bt;
      logic [2:0]  mv;
      logic [7:0]  src;
      logic [31:0] gin;
   } bun_t;

   typedef struct {
      string       name;
      logic [31:0] init;
      bun_t        b;
      logic [31:0] exp_cr;
      logic        exp_gwe;
      logic [31:0] exp_gout;
   } vec_t;

   vec_t        vecs[$];
   bun_t        q[$];
   bun_t        cur;
   logic [31:0] model_cr;

   function automatic bun_t mkb(input logic c, input logic [2:0] op, input logic [4:0] ba,
                                input logic [4:0] bb, input logic [4:0] bt, input logic [2:0] mv,
                                input logic [7:0] src, input logic [31:0] gin);
      bun_t b;
      b.crl_en = c; b.op = op; b.ba = ba; b.bb = bb; b.bt = bt;
      b.mv = mv; b.src = src; b.gin = gin;
      return b;
   endfunction

   function automatic vec_t mkv(input string n, input logic [31:0] init, input bun_t b,
                                input logic [31:0] ecr, input logic egwe, input logic [31:0] egout);
      vec_t v;
      v.name = n; v.init = init; v.b = b; v.exp_cr = ecr; v.exp_gwe = egwe; v.exp_gout = egout;
      return v;
   endfunction

   // CR field f is the nibble at bit offset 28-4f
   function automatic logic [3:0] get_fld(input logic [31:0] c, input int f);
      logic [31:0] t;
      t = (c >> (28 - 4 * f)) & 32'hF;
      return t[3:0];
   endfunction

   function automatic logic [31:0] put_fld(input logic [31:0] c, input int f, input logic [3:0] v);
      return (c & ~(32'hF << (28 - 4 * f))) | ({28'd0, v} << (28 - 4 * f));
   endfunction

   // Architectural effect of one bundle applied in program order
   function automatic void model_exec(input bun_t b, inout logic [31:0] c,
                                      output logic gwe, output logic [31:0] gout);
      logic a, bb, r;
      gwe = 1'b0;
      gout = 32'h0;
      r = 1'b0;
      if (b.crl_en) begin
         a  = c[31 - int'(b.ba)];
         bb = c[31 - int'(b.bb)];
         case (b.op)
            3'd0: r = a & bb;
            3'd1: r = !(a & bb);
            3'd2: r = a | bb;
            3'd3: r = !(a | bb);
            3'd4: r = a ^ bb;
            3'd5: r = !(a ^ bb);
            3'd6: r = a & !bb;
            default: r = a | !bb;
         endcase
         c[31 - int'(b.bt)] = r;
      end else begin
         case (b.mv)
            3'd1: begin
               for (int f = 0; f < 8; f++) begin
                  if (b.src[7 - f]) begin
                     c = put_fld(c, int'(b.bt[4:2]), get_fld(c, f));
                     break;
                  end
               end
            end
            3'd2: for (int f = 0; f < 8; f++) if (b.src[7 - f]) c = put_fld(c, f, get_fld(b.gin, f));
            3'd3: begin
               gwe = 1'b1;
               for (int f = 0; f < 8; f++) if (b.src[7 - f]) gout = put_fld(gout, f, get_fld(c, f));
            end
            default: ;
         endcase
      end
   endfunction

   function automatic bun_t rnd_bundle();
      bun_t b;
      b.crl_en = ($urandom_range(2) == 0);
      b.op  = 3'($urandom_range(7));
      b.ba  = 5'($urandom_range(31));
      b.bb  = 5'($urandom_range(31));
      b.bt  = 5'($urandom_range(31));
      b.mv  = 3'($urandom_range(4));
      b.src = 8'($urandom_range(255));
      if (b.mv == 3'd1) b.src = 8'(1 << $urandom_range(7));
      b.gin = $urandom;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s", name, why);
   endtask

   task automatic drive(input bun_t b);
      ifc.crl_en = b.crl_en; ifc.cr_op = b.op; ifc.crl_ba = b.ba; ifc.crl_bb = b.bb;
      ifc.crl_bt = b.bt; ifc.reg_mv = b.mv; ifc.src_cr = b.src; ifc.gpr_in = b.gin;
   endtask

   task automatic bus_idle();
      drive('0);
      ifc.in_valid = 1'b0;
      ifc.stall = 1'b0;
   endtask

   task automatic do_reset();
      bus_idle();
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bun_t b, output int acc);
      bit done;
      done = 1'b0;
      acc = -1;
      drive(b);
      ifc.in_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (ifc.in_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
            done = 1'b1;
         end
      end
      ifc.in_valid = 1'b0;
      if (!done) fail_now("send", "in_ready never seen");
   endtask

   task automatic wait_retire(output logic gwe, output logic [31:0] gout);
      bit done;
      done = 1'b0;
      gwe = 1'b0;
      gout = 32'h0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (ifc.out_valid && !ifc.stall) begin
            gwe = ifc.gpr_we;
            gout = ifc.gpr_out;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) fail_now("retire", "out_valid never seen");
   endtask

   task automatic run_one(input bun_t b, output logic gwe, output logic [31:0] gout);
      int a;
      send(b, a);
      wait_retire(gwe, gout);
   endtask

   task automatic rnd_step(input bit allow_new);
      logic        gwe_e;
      logic [31:0] gout_e;
      bun_t        b;
      bit          accepted;
      @(negedge clk);
      if (ifc.out_valid && !ifc.stall) begin
         if (q.size() == 0) begin
            fail_now("rnd_retire", "retire with nothing outstanding");
         end else begin
            b = q.pop_front();
            model_exec(b, model_cr, gwe_e, gout_e);
            chk("rnd_gpr_we", 32'(ifc.gpr_we), 32'(gwe_e));
            chk("rnd_gpr_out", ifc.gpr_out, gout_e);
         end
      end
      if (!ifc.out_valid) chk("rnd_idle_gpr_out", ifc.gpr_out, 32'h0);
      if (ifc.stall) chk("rnd_stall_in_ready", 32'(ifc.in_ready), 32'h0);
      accepted = ifc.in_valid && ifc.in_ready;
      if (accepted) q.push_back(cur);
      @(posedge clk);
      #1;
      chk("rnd_cr", ifc.cr, model_cr);
      if (allow_new) begin
         ifc.stall = ($urandom_range(3) == 0);
         if (!ifc.in_valid || accepted) begin
            cur = rnd_bundle();
            drive(cur);
            ifc.in_valid = ($urandom_range(3) != 0);
         end
      end else begin
         ifc.stall = 1'b0;
         ifc.in_valid = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        g;
      logic [31:0] go;
      int          ca, cb, exp_gap;
      int          rets[$];

      vecs.push_back(mkv("crnor",      32'h0000_0000, mkb(1, 3, 1, 2, 0, 0, 8'h00, 0), 32'h8000_0000, 0, 32'h0));
      vecs.push_back(mkv("ctg_f1",     32'h1234_5678, mkb(0, 0, 0, 0, 0, 3, 8'h40, 0), 32'h1234_5678, 1, 32'h0200_0000));
      vecs.push_back(mkv("mcrf_f0_f1", 32'hA123_4567, mkb(0, 0, 0, 0, 5'b00100, 1, 8'h80, 0), 32'hAA23_4567, 0, 32'h0));
      vecs.push_back(mkv("crand",      32'hC000_0000, mkb(1, 0, 0, 1, 3, 0, 8'h00, 0), 32'hD000_0000, 0, 32'h0));
      vecs.push_back(mkv("crxor_b31",  32'h8000_0000, mkb(1, 4, 0, 1, 31, 0, 8'h00, 0), 32'h8000_0001, 0, 32'h0));
      vecs.push_back(mkv("crandc",     32'h8000_0000, mkb(1, 6, 0, 1, 2, 0, 8'h00, 0), 32'hA000_0000, 0, 32'h0));
      vecs.push_back(mkv("crorc_clr",  32'h8400_0000, mkb(1, 7, 4, 5, 0, 0, 8'h00, 0), 32'h0400_0000, 0, 32'h0));
      vecs.push_back(mkv("gtc_f0_f7",  32'h1234_5678, mkb(0, 0, 0, 0, 0, 2, 8'h81, 32'hFFFF_FFFF), 32'hF234_567F, 0, 32'h0));
      vecs.push_back(mkv("mv_invalid", 32'h5555_AAAA, mkb(0, 0, 0, 0, 0, 4, 8'hFF, 32'h0), 32'h5555_AAAA, 0, 32'h0));
      vecs.push_back(mkv("crl_prio",   32'h0000_0000, mkb(1, 5, 0, 0, 1, 3, 8'hFF, 0), 32'h4000_0000, 0, 32'h0));
      vecs.push_back(mkv("crnand",     32'h0100_0000, mkb(1, 1, 7, 7, 7, 0, 8'h00, 0), 32'h0000_0000, 0, 32'h0));
      vecs.push_back(mkv("cror",       32'h0080_0000, mkb(1, 2, 7, 8, 10, 0, 8'h00, 0), 32'h00A0_0000, 0, 32'h0));
      vecs.push_back(mkv("ctg_all",    32'hDEAD_BEEF, mkb(0, 0, 0, 0, 0, 3, 8'hFF, 0), 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF));
      vecs.push_back(mkv("ctg_f7",     32'hDEAD_BEEF, mkb(0, 0, 0, 0, 0, 3, 8'h01, 0), 32'hDEAD_BEEF, 1, 32'h0000_000F));
      vecs.push_back(mkv("mcrf_f7_f0", 32'h1234_567B, mkb(0, 0, 0, 0, 5'b00011, 1, 8'h01, 0), 32'hB234_567B, 0, 32'h0));

`ifdef FXDP_CR_FWD_EN
      exp_gap = 1;
`else
      exp_gap = 2;
`endif

      // reset state and in_ready release timing
      bus_idle();
      #1 reset = 1'b0;
      #1;
      chk("rst_cr", ifc.cr, 32'h0);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
      chk("rst_in_ready", 32'(ifc.in_ready), 32'h0);
      chk("rst_gpr_we", 32'(ifc.gpr_we), 32'h0);
      chk("rst_gpr_out", ifc.gpr_out, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      #1 chk("rel_in_ready_pre_edge", 32'(ifc.in_ready), 32'h0);
      @(posedge clk);
      #1 chk("rel_in_ready_post_edge", 32'(ifc.in_ready), 32'h1);

      // table vectors: preload CR with gtc of all fields, then one bundle
      foreach (vecs[i]) begin
         do_reset();
         run_one(mkb(0, 0, 0, 0, 0, 3'd2, 8'hFF, vecs[i].init), g, go);
         run_one(vecs[i].b, g, go);
         chk({vecs[i].name, "_cr"}, ifc.cr, vecs[i].exp_cr);
         chk({vecs[i].name, "_gpr_we"}, 32'(g), 32'(vecs[i].exp_gwe));
         chk({vecs[i].name, "_gpr_out"}, go, vecs[i].exp_gout);
      end

      // crnor commit lands exactly two edges after acceptance
      do_reset();
      send(mkb(1, 3, 1, 2, 0, 0, 8'h00, 0), ca);
      chk("crnor_edge0_cr", ifc.cr, 32'h0);
      @(posedge clk);
      #1 chk("crnor_edge1_cr", ifc.cr, 32'h0);
      chk("crnor_edge1_out_valid", 32'(ifc.out_valid), 32'h1);
      @(posedge clk);
      #1 chk("crnor_edge2_cr", ifc.cr, 32'h8000_0000);

      // back-to-back dependent crand -> cror through CR bit 3
      do_reset();
      run_one(mkb(0, 0, 0, 0, 0, 3'd2, 8'hFF, 32'hC000_0000), g, go);
      send(mkb(1, 0, 0, 1, 3, 0, 8'h00, 0), ca);
      send(mkb(1, 2, 3, 5, 4, 0, 8'h00, 0), cb);
      chk("b2b_accept_gap", 32'(cb - ca), 32'h1);
      rets.delete();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) chk("b2b_in_ready", 32'(ifc.in_ready), 32'(exp_gap == 1));
         if (ifc.out_valid) rets.push_back(cyc);
         @(posedge clk);
         #1;
      end
      chk("b2b_retire_count", 32'(rets.size()), 32'h2);
      if (rets.size() == 2) chk("b2b_retire_gap", 32'(rets[1] - rets[0]), 32'(exp_gap));
      chk("b2b_cr", ifc.cr, 32'hD800_0000);

      // three stall cycles with S2 holding a pending write
      do_reset();
      send(mkb(0, 0, 0, 0, 0, 3'd2, 8'hF0, 32'h9ABC_DEF0), ca);
      @(posedge clk);
      #1 ifc.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(ifc.out_valid), 32'h1);
         chk("stall_in_ready", 32'(ifc.in_ready), 32'h0);
         @(posedge clk);
         #1 chk("stall_cr", ifc.cr, 32'h0);
      end
      ifc.stall = 1'b0;
      @(negedge clk);
      chk("unstall_out_valid", 32'(ifc.out_valid), 32'h1);
      @(posedge clk);
      #1 chk("unstall_cr", ifc.cr, 32'h9ABC_0000);
      chk("unstall_out_valid_after", 32'(ifc.out_valid), 32'h0);

      // reset with both stages full squashes them
      do_reset();
      send(mkb(0, 0, 0, 0, 0, 3'd2, 8'hFF, 32'hFFFF_FFFF), ca);
      send(mkb(0, 0, 0, 0, 0, 3'd2, 8'hFF, 32'h0F0F_0F0F), cb);
      chk("squash_pre_out_valid", 32'(ifc.out_valid), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("squash_cr", ifc.cr, 32'h0);
      chk("squash_out_valid", 32'(ifc.out_valid), 32'h0);
      chk("squash_in_ready", 32'(ifc.in_ready), 32'h0);
      chk("squash_gpr_out", ifc.gpr_out, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1 chk("squash_rel_in_ready", 32'(ifc.in_ready), 32'h1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("squash_late_out_valid", 32'(ifc.out_valid), 32'h0);
         @(posedge clk);
         #1 chk("squash_late_cr", ifc.cr, 32'h0);
      end

      // randomized traffic against the in-order architectural model
      do_reset();
      model_cr = 32'h0;
      q.delete();
      cur = '0;
      for (int i = 0; i < 800; i++) rnd_step(1'b1);
      for (int k = 0; k < 40 && (q.size() != 0 || ifc.out_valid); k++) rnd_step(1'b0);
      chk("rnd_drain_empty", 32'(q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fxdp_cr_exec.md
FXDP_CR_EXEC -- requirements
Module: fxdp_cr_exec

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; asserted at 0.
REQ-003 SHALL have ports: in_valid  in  1  decoded control bundle valid.
REQ-004 SHALL have ports: in_ready  out  1  bundle accepted when in_valid & in_ready.
REQ-005 SHALL have ports: crl_en  in  1  CR logical op.
REQ-006 SHALL have ports: cr_op  in  3  and=0 nand=1 or=2 nor=3 xor=4 eqv=5 andc=6 orc=7.
REQ-007 SHALL have ports: crl_ba, crl_bb, crl_bt  in  5 each  CR bit indices; crl_bt[4:2] is the mcrf target field.
REQ-008 SHALL have ports: reg_mv  in  3  none=0, ctc(mcrf)=1, gtc(mtocrf)=2, ctg(mfocrf)=3; other values mean none.
REQ-009 SHALL have ports: src_cr  in  8  field mask; bit 7 = CR field 0.
REQ-010 SHALL have ports: gpr_in  in  32  source GPR for gtc.
REQ-011 SHALL have ports: stall  in  1  downstream hold.
REQ-012 SHALL have ports: out_valid  out  1;  gpr_we  out  1;  gpr_out  out  32;  cr  out  32  architectural CR.

Function
REQ-013 SHALL number CR bit n as cr[31-n]; field f SHALL be cr[31-4f : 28-4f].
REQ-014 SHALL implement two stages, S1 (operand/compute) and S2 (retire), each holding a valid bit.
REQ-015 SHALL capture an accepted bundle into S1 at the accepting edge, move it to S2 one edge later, and present the result with out_valid=1 from S2.
REQ-016 SHALL commit the CR write of S2 at the edge where out_valid & !stall; cr SHALL reflect committed state only.
REQ-017 SHALL, while stall=1, hold S1, S2, and cr unchanged, and drive in_ready=0.
REQ-018 SHALL, for crl_en, compute CR[bt] = op(CR[ba], CR[bb]), with andc = a&~b and orc = a|~b.
REQ-019 SHALL, for ctc, copy the field selected by the single set bit of src_cr into field crl_bt[4:2].
REQ-020 SHALL, for gtc, write gpr_in into each CR field whose src_cr bit is set, leaving other fields unchanged.
REQ-021 SHALL, for ctg, drive gpr_out = CR with unselected fields zeroed and gpr_we=1; gpr_we SHALL be 0 for all other ops.
REQ-022 SHALL give crl_en priority if both crl_en and reg_mv≠none; none/invalid SHALL retire with no CR write.
REQ-023 SHALL read S1 operands from cr merged with the pending S2 write (see REQ-029).
REQ-024 SHALL treat in_valid=0 as a bubble; gpr_out SHALL be 0 when out_valid=0.

Reset
REQ-025 SHALL, on reset=0, immediately clear S1/S2 valid, cr=0, out_valid=0, gpr_we=0, gpr_out=0, in_ready=0.
REQ-026 SHALL squash in-flight bundles on reset mid-operation; no CR write from them SHALL ever occur.
REQ-027 SHALL drive in_ready=!stall from the first edge after reset release.

Configuration
REQ-028 SHALL use macro FXDP_CR_FWD_EN.
REQ-029 SHALL, with FXDP_CR_FWD_EN defined, forward the S2 pending CR value into S1 operands bit-exactly, so back-to-back dependents never stall.
REQ-030 SHALL, without FXDP_CR_FWD_EN, drive in_ready=0 for one cycle while S2 holds an uncommitted CR write and a new bundle would read CR, so that no forwarding path exists.

Verification
REQ-031 SHALL cover: cr=0, crnor bt=0 ba=1 bb=2 -> cr=0x8000_0000 two edges after acceptance.
REQ-032 SHALL cover: gtc gpr_in=0x1234_5678 src_cr=0xFF, then ctg src_cr=0x40 -> gpr_out=0x0200_0000 with gpr_we=1.
REQ-033 SHALL cover: mcrf src_cr=0x80 crl_bt=5'b00100 with field0=0xA -> field1=0xA, other fields unchanged.
REQ-034 SHALL cover: back-to-back crand writing bit 3 then cror reading bit 3 -> correct result; zero bubbles with FXDP_CR_FWD_EN, one bubble without it.
REQ-035 SHALL cover: stall=1 for 3 cycles with S2 valid -> out_valid held, cr unchanged, in_ready=0; commit occurs on the first !stall edge.
REQ-036 SHALL cover: reset=0 asserted with S1 and S2 full -> cr=0 and out_valid=0 immediately, with no late commit after release.
